// File: rtl/serial_frame_receiver.sv
// Serial deframer: start bit 1, 8 data bits LSB first, optional parity, stop bit 0.
// Good bytes are held on a valid/ready output register; errors pulse for one cycle.
module serial_frame_receiver #(
   parameter bit PARITY_EN  = 1'b1,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serIn,
   input  logic       byteReady,
   output logic [7:0] byteOut,
   output logic       byteValid,
   output logic       parityErr,
   output logic       frameErr,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   count;
   logic [DATA_W-1:0]  shreg;
   logic               par_bit;

   logic               start_c;
   logic               shift_c;
   logic               cap_par_c;
   logic               eval_c;
   logic               par_bad_c;
   logic               stop_bad_c;
   logic               good_c;
   logic               load_c;
   logic               accept_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (serIn) next_state = DATA;
         DATA:    if (count == CNT_W'(DATA_W - 1)) next_state = PARITY_EN ? PARITY : STOP;
         PARITY:  next_state = STOP;
         STOP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Per-state control and frame evaluation
   always_comb begin
      start_c    = 1'b0;
      shift_c    = 1'b0;
      cap_par_c  = 1'b0;
      eval_c     = 1'b0;
      case (state)
         IDLE:    start_c   = serIn;
         DATA:    shift_c   = 1'b1;
         PARITY:  cap_par_c = 1'b1;
         STOP:    eval_c    = 1'b1;
         default: ;
      endcase
      par_bad_c  = PARITY_EN && ((^shreg ^ par_bit) != ODD_PARITY);
      stop_bad_c = serIn;
      good_c     = eval_c && !stop_bad_c && !par_bad_c;
      accept_c   = byteValid && byteReady;
      load_c     = good_c && (!byteValid || byteReady);
   end

   // Receive datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         if (start_c)        count <= '0;
         else if (shift_c)   count <= count + CNT_W'(1);
         if (shift_c)        shreg[count] <= serIn;
         if (cap_par_c)      par_bit <= serIn;
      end
   end

   // Output register and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         byteOut   <= '0;
         byteValid <= 1'b0;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         parityErr <= eval_c && par_bad_c;
         frameErr  <= eval_c && stop_bad_c;
         overrun   <= good_c && byteValid && !byteReady;
         busy      <= (next_state != IDLE);
         if (load_c) begin
            byteOut   <= shreg;
            byteValid <= 1'b1;
         end else if (accept_c) begin
            byteValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: directed plan steps plus random
// frames against a frame-level reference model.
module tb_serial_frame_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       ser;
   logic       rdy;
   logic [7:0] out;
   logic       valid, perr, ferr, ovr, busy;

   logic       ser2;
   logic       rdy2;
   logic [7:0] out2;
   logic       valid2, perr2, ferr2, ovr2, busy2;

   int checks   = 0;
   int failures = 0;

   // reference model state for the parity-enabled instance
   logic [7:0] exp_out;
   logic       exp_valid;

   always #5 clk = ~clk;

   serial_frame_receiver #(.PARITY_EN(1'b1), .ODD_PARITY(1'b0)) u_dut (
      .clk(clk), .rst(rst), .serIn(ser), .byteReady(rdy),
      .byteOut(out), .byteValid(valid), .parityErr(perr),
      .frameErr(ferr), .overrun(ovr), .busy(busy)
   );

   serial_frame_receiver #(.PARITY_EN(1'b0), .ODD_PARITY(1'b0)) u_np (
      .clk(clk), .rst(rst), .serIn(ser2), .byteReady(rdy2),
      .byteOut(out2), .byteValid(valid2), .parityErr(perr2),
      .frameErr(ferr2), .overrun(ovr2), .busy(busy2)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag, input logic ebusy, input logic epe,
                            input logic efe, input logic eov);
      chk({tag, ".byteOut"},   out,          exp_out);
      chk({tag, ".byteValid"}, 8'(valid),    8'(exp_valid));
      chk({tag, ".parityErr"}, 8'(perr),     8'(epe));
      chk({tag, ".frameErr"},  8'(ferr),     8'(efe));
      chk({tag, ".overrun"},   8'(ovr),      8'(eov));
      chk({tag, ".busy"},      8'(busy),     8'(ebusy));
   endtask

   // One clock: drive at negedge, apply frame-level rules at posedge, check after it.
   task automatic tick(input string tag, input logic s, input logic r, input logic ebusy,
                       input logic is_stop, input logic [7:0] d,
                       input logic bad_par, input logic bad_stop);
      logic good, epe, efe, eov;
      @(negedge clk);
      ser = s;
      rdy = r;
      @(posedge clk);
      epe  = is_stop && bad_par;
      efe  = is_stop && bad_stop;
      good = is_stop && !bad_par && !bad_stop;
      eov  = good && exp_valid && !r;
      if (good && (!exp_valid || r)) begin
         exp_out   = d;
         exp_valid = 1'b1;
      end else if (exp_valid && r) begin
         exp_valid = 1'b0;
      end
      #1;
      check_all(tag, ebusy, epe, efe, eov);
   endtask

   task automatic idle(input string tag, input logic r);
      tick(tag, 1'b0, r, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Whole frame: start, 8 data LSB first, even parity (optionally flipped), stop.
   task automatic send_frame(input string tag, input logic [7:0] d, input logic bad_par,
                             input logic bad_stop, input logic rand_rdy, input logic r_stop);
      logic [10:0] bits;
      logic        r;
      bits = {bad_stop, (^d) ^ bad_par, d, 1'b1};
      for (int i = 0; i < 11; i++) begin
         r = (i == 10) ? r_stop : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0);
         tick(tag, bits[i], r, (i < 10), (i == 10), d, bad_par, bad_stop);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [9:0] nbits;
      rst = 1'b1; ser = 1'b0; rdy = 1'b0; ser2 = 1'b0; rdy2 = 1'b0;
      exp_out = 8'h00; exp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.np_busy", 8'(busy2), 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // good 0xA5, held until byteReady
      send_frame("a5_good", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) idle("a5_hold", 1'b0);
      idle("a5_accept", 1'b1);
      idle("a5_after", 1'b0);

      // bad parity: dropped, byteOut unchanged
      send_frame("a5_badpar", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle("badpar_after", 1'b0);

      // bad stop, then 0x01 right behind it
      send_frame("3c_badstop", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame("01_after", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      idle("01_drain", 1'b1);

      // back-to-back with full buffer: overrun, then with accept on second stop
      send_frame("b2b_11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame("b2b_22_ovr", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      idle("b2b_drain", 1'b1);
      send_frame("b2b_11b", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame("b2b_22_acc", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
      idle("b2b_hold", 1'b0);

      // reset at data bit 4, held two cycles, aborts silently
      tick("rst_mid", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         tick("rst_mid", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      ser = 1'b1;
      repeat (2) @(posedge clk);
      exp_out = 8'h00; exp_valid = 1'b0;
      #1;
      check_all("rst_mid_after", 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      ser = 1'b0;
      send_frame("ff_fresh", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      idle("ff_drain", 1'b1);

      // no-parity instance: 0x80 valid after the 10th edge, not before
      nbits = {1'b0, 8'h80, 1'b1};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         ser2 = nbits[i];
         rdy2 = 1'b0;
         @(posedge clk);
         #1;
         chk("np80.byteValid", 8'(valid2), 8'((i == 9) ? 1 : 0));
         chk("np80.busy", 8'(busy2), 8'((i < 9) ? 1 : 0));
      end
      chk("np80.byteOut", out2, 8'h80);
      chk("np80.flags", 8'({perr2, ferr2, ovr2}), 8'h00);

      // random frames with random errors, handshakes and gaps
      for (int n = 0; n < 60; n++) begin
         d = 8'($urandom);
         send_frame("rand", d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'b1, 1'($urandom_range(0, 1)));
         for (int g = $urandom_range(0, 2); g > 0; g--)
            idle("rand_gap", 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Deframes a one-bit-per-clock serial stream into bytes. It watches the same serial line that feeds the 8-bit shift register stage, detects start bits, collects 8 data bits LSB-first with optional parity, and checks the stop bit. It presents each good byte on a valid/ready output register and flags parity, framing and overrun errors for the downstream consumer.

## Interface
- PARITY_EN, 1, 1 = frame carries a parity bit after the data bits; 0 = no parity bit.
- ODD_PARITY, 0, 0 = even parity (data ones + parity bit is even); 1 = odd parity.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- serIn  input  1  serial line. Idles at 0.
- byteReady  input  1  consumer accepts byteOut on an edge where byteValid=1.
- byteOut  output  8  last accepted frame's data, bit 0 = first data bit received.
- byteValid  output  1  byteOut holds an unconsumed byte.
- parityErr  output  1  one-cycle pulse: a frame was dropped for bad parity.
- frameErr  output  1  one-cycle pulse: a frame was dropped for a bad stop bit.
- overrun  output  1  one-cycle pulse: a good frame was dropped because the buffer was full.
- busy  output  1  high while a frame is being received (any state except IDLE).

## Operation
- Frame format: start bit = 1, then 8 data bits LSB first, then a parity bit if PARITY_EN=1, then stop bit = 0.
- FSM states:
  - IDLE: on serIn=1, go to DATA and clear the bit counter. Otherwise stay.
  - DATA: shift serIn into the data shift register at bit position count, then count+1. After the 8th bit, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: capture serIn as the parity bit, then go to STOP.
  - STOP: sample serIn, evaluate the frame, then always go to IDLE.
- Stop sampled as 0 and parity correct (or PARITY_EN=0) makes the frame good.
- Frame evaluation in STOP:
  - Stop bit = 1: pulse frameErr and drop the frame. This 1 is not reinterpreted as a start bit.
  - Parity mismatch: pulse parityErr and drop the frame.
  - Both conditions true: pulse both flags.
- Good frame delivery:
  - byteValid=0, or byteValid=1 with byteReady=1 on that edge: load byteOut and set byteValid=1.
  - byteValid=1 with byteReady=0: pulse overrun, drop the new byte. byteOut and byteValid are unchanged.
- Handshake:
  - byteValid stays high until an edge with byteReady=1.
  - On that edge byteValid clears, unless a good frame loads on the same edge.
  - byteOut is stable while byteValid=1 and not yet accepted.
  - byteReady is ignored when byteValid=0.
- Reset:
  - All outputs reset to 0: byteOut=8'h00, byteValid=0, parityErr=0, frameErr=0, overrun=0, busy=0.
  - State returns to IDLE; the bit counter and shift register clear.
  - Reset mid-frame aborts the frame silently, with no flags.

## Timing
- Let the start bit be sampled at edge T.
  - Data bits are sampled at T+1..T+8.
  - Parity is sampled at T+9, and stop at T+10 (T+9 if PARITY_EN=0).
- byteValid rises, or an error flag pulses, from the edge that samples stop. The result is visible in the cycle after that edge: 11 cycles after the start bit with parity, 10 without.
- busy is high from after edge T until the stop-sampling edge, then low.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop edge. There are zero idle cycles between frames.
- Error and overrun pulses last exactly one cycle.

## Test plan
- Reset, then frame 0xA5 (PARITY_EN=1, even: serIn 1; 1,0,1,0,0,1,0,1; parity 0; stop 0) with byteReady=0 -> byteOut=8'hA5, byteValid=1 eleven cycles after start. byteValid stays high until byteReady=1, then clears the next edge.
- Same frame with parity bit 1 -> parityErr one-cycle pulse; byteValid stays 0; byteOut unchanged.
- Frame 0x3C with stop bit 1 -> frameErr pulse; FSM back in IDLE; the following 0x01 frame is received correctly.
- Two back-to-back frames 0x11, 0x22 with byteReady=0 -> byteOut=8'h11 retained and overrun pulses at the second stop. Repeat with byteReady=1 on the second stop edge -> byteOut=8'h22 and byteValid stays 1.
- rst asserted at data bit 4 of a frame for 2 cycles -> all outputs 0 and busy=0 after the reset edge, no flags. A fresh frame 0xFF received afterwards is correct.
- PARITY_EN=0, frame 0x80 -> byteValid ten cycles after start, byteOut=8'h80.
